// File: rtl/aes_pkg.sv
// Shared definitions for the CTR controller: block width, FSM states and
// the width helper used by the credit counters.
package aes_pkg;

    localparam int AES_BLOK_GENISLIK  = 128;
    localparam int BLOK_SAYI_GENISLIK = 16;

    typedef enum logic [1:0] {
        DURUM_BOS       = 2'd0,
        DURUM_CALISIYOR = 2'd1,
        DURUM_BOSALT    = 2'd2
    } durum_t;

    // Width that can hold 0..derinlik inclusive (occupancy / in-flight count).
    function automatic int kredi_genislik(input int derinlik);
        return $clog2(derinlik + 1);
    endfunction

endpackage

// File: rtl/aes_ctr_denetleyici_if.sv
// Data stream and aes_engine link of the CTR controller. The master modport
// is the controller's view, the slave modport the source/sink and engine side.
interface aes_ctr_denetleyici_if;
    import aes_pkg::*;

    logic [AES_BLOK_GENISLIK-1:0] d_blok;
    logic                         d_gecerli;
    logic                         d_hazir;
    logic [AES_BLOK_GENISLIK-1:0] e_blok;
    logic                         e_gecerli;
    logic                         e_hazir;
    logic [AES_BLOK_GENISLIK-1:0] e_sifre;
    logic                         e_c_gecerli;
    logic [AES_BLOK_GENISLIK-1:0] cikti;
    logic                         cikti_gecerli;

    modport master (
        input  d_blok, d_gecerli, e_hazir, e_sifre, e_c_gecerli,
        output d_hazir, e_blok, e_gecerli, cikti, cikti_gecerli
    );

    modport slave (
        output d_blok, d_gecerli, e_hazir, e_sifre, e_c_gecerli,
        input  d_hazir, e_blok, e_gecerli, cikti, cikti_gecerli
    );

endinterface

// File: rtl/aes_ctr_fifo.sv
// Keystream FIFO: synchronous, 128-bit entries, power-of-two depth.
module aes_ctr_fifo
    import aes_pkg::*;
#(
    parameter  int DERINLIK = 8,
    localparam int AW       = $clog2(DERINLIK),
    localparam int SW       = kredi_genislik(DERINLIK)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         yaz,
    input  logic [AES_BLOK_GENISLIK-1:0] yaz_veri,
    input  logic                         oku,
    output logic [AES_BLOK_GENISLIK-1:0] oku_veri,
    output logic                         dolu,
    output logic                         bos,
    output logic [SW-1:0]                doluluk
);

    logic [AES_BLOK_GENISLIK-1:0] mem [DERINLIK];
    logic [AW-1:0]                yaz_ptr, oku_ptr;
    logic                         yaz_ok, oku_ok;

    assign dolu     = (doluluk == SW'(DERINLIK));
    assign bos      = (doluluk == '0);
    assign yaz_ok   = yaz && (!dolu || oku);
    assign oku_ok   = oku && !bos;
    assign oku_veri = mem[oku_ptr];

    always_ff @(posedge clk) begin
        if (yaz_ok) mem[yaz_ptr] <= yaz_veri;
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            yaz_ptr <= '0;
            oku_ptr <= '0;
            doluluk <= '0;
        end else begin
            if (yaz_ok) yaz_ptr <= yaz_ptr + 1'b1;
            if (oku_ok) oku_ptr <= oku_ptr + 1'b1;
            doluluk <= doluluk + SW'(yaz_ok) - SW'(oku_ok);
        end
    end

endmodule

// File: rtl/aes_ctr_denetleyici.sv
// CTR-mode controller around aes_engine: issues counter blocks under a credit
// limit, buffers keystream and XORs it onto the data stream.
// Optional: AES_CTR_TASMA_KONTROL_EN flags counter wrap on the sticky hata output.
module aes_ctr_denetleyici
    import aes_pkg::*;
#(
    parameter int FIFO_DERINLIK  = 8,
    parameter int SAYAC_GENISLIK = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [AES_BLOK_GENISLIK-SAYAC_GENISLIK-1:0] nonce,
    input  logic [SAYAC_GENISLIK-1:0]             sayac_ilk,
    input  logic [BLOK_SAYI_GENISLIK-1:0]         blok_sayisi,
    input  logic                                  baslat,
    aes_ctr_denetleyici_if.master                 bag,
    output logic                                  bitti
`ifdef AES_CTR_TASMA_KONTROL_EN
    ,
    output logic                                  hata
`endif
);

    localparam int NW = AES_BLOK_GENISLIK - SAYAC_GENISLIK;
    localparam int KW = kredi_genislik(FIFO_DERINLIK);
    localparam logic [KW:0] KREDI_SINIR = (KW + 1)'(FIFO_DERINLIK);

    durum_t                        durum, durum_sonraki;
    logic [NW-1:0]                 nonce_reg;
    logic [SAYAC_GENISLIK-1:0]     sayac_reg;
    logic [BLOK_SAYI_GENISLIK-1:0] kalan_ihrac, kalan_cikti;
    logic [KW-1:0]                 ucusta, doluluk;
    logic                          fifo_dolu, fifo_bos;
    logic [AES_BLOK_GENISLIK-1:0]  fifo_veri, cikti_reg;
    logic                          cikti_gecerli_reg;
    logic                          kredi_var, ihrac, kabul, son_cikti, tasma_dur, bos_is;

`ifdef AES_CTR_TASMA_KONTROL_EN
    logic hata_reg;
    assign hata      = hata_reg;
    assign tasma_dur = hata_reg;
`else
    assign tasma_dur = 1'b0;
`endif

    aes_ctr_fifo #(.DERINLIK(FIFO_DERINLIK)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .yaz      (bag.e_c_gecerli),
        .yaz_veri (bag.e_sifre),
        .oku      (kabul),
        .oku_veri (fifo_veri),
        .dolu     (fifo_dolu),
        .bos      (fifo_bos),
        .doluluk  (doluluk)
    );

    // Credit: never have more blocks outstanding than the FIFO can hold.
    assign kredi_var     = (({1'b0, ucusta} + {1'b0, doluluk}) < KREDI_SINIR) && !fifo_dolu;
    assign bag.e_gecerli = (durum == DURUM_CALISIYOR) && (kalan_ihrac != '0) && kredi_var && !tasma_dur;
    assign bag.e_blok    = {nonce_reg, sayac_reg};
    assign ihrac         = bag.e_gecerli && bag.e_hazir;

    assign bag.d_hazir       = !fifo_bos && (kalan_cikti != '0) && (durum != DURUM_BOS);
    assign kabul             = bag.d_gecerli && bag.d_hazir;
    assign son_cikti         = kabul && (kalan_cikti == BLOK_SAYI_GENISLIK'(1));
    assign bos_is            = (durum == DURUM_BOS) && baslat && (blok_sayisi == '0);
    assign bag.cikti         = cikti_reg;
    assign bag.cikti_gecerli = cikti_gecerli_reg;

    always_comb begin
        durum_sonraki = durum;
        case (durum)
            DURUM_BOS:       if (baslat && blok_sayisi != '0) durum_sonraki = DURUM_CALISIYOR;
            DURUM_CALISIYOR: begin
                if (son_cikti)                                                 durum_sonraki = DURUM_BOS;
                else if (ihrac && kalan_ihrac == BLOK_SAYI_GENISLIK'(1))       durum_sonraki = DURUM_BOSALT;
            end
            DURUM_BOSALT:    if (son_cikti) durum_sonraki = DURUM_BOS;
            default:         durum_sonraki = DURUM_BOS;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            durum             <= DURUM_BOS;
            nonce_reg         <= '0;
            sayac_reg         <= '0;
            kalan_ihrac       <= '0;
            kalan_cikti       <= '0;
            ucusta            <= '0;
            cikti_reg         <= '0;
            cikti_gecerli_reg <= 1'b0;
            bitti             <= 1'b0;
`ifdef AES_CTR_TASMA_KONTROL_EN
            hata_reg          <= 1'b0;
`endif
        end else begin
            durum <= durum_sonraki;
            if (durum == DURUM_BOS && baslat) begin
                nonce_reg   <= nonce;
                sayac_reg   <= sayac_ilk;
                kalan_ihrac <= blok_sayisi;
                kalan_cikti <= blok_sayisi;
            end else begin
                if (ihrac) begin
                    sayac_reg   <= sayac_reg + 1'b1;
                    kalan_ihrac <= kalan_ihrac - 1'b1;
                end
                if (kabul) kalan_cikti <= kalan_cikti - 1'b1;
            end
            ucusta            <= ucusta + KW'(ihrac) - KW'(bag.e_c_gecerli);
            cikti_gecerli_reg <= kabul;
            if (kabul) cikti_reg <= bag.d_blok ^ fifo_veri;
            bitti <= (son_cikti && !tasma_dur) || bos_is;
`ifdef AES_CTR_TASMA_KONTROL_EN
            // Issuing the all-ones counter with more blocks pending means the next one would wrap.
            if (ihrac && (&sayac_reg) && kalan_ihrac > BLOK_SAYI_GENISLIK'(1)) hata_reg <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_aes_ctr_denetleyici.sv
// Scoreboard bench for aes_ctr_denetleyici with a 3-stage pipelined engine model.
module tb_aes_ctr_denetleyici;

    localparam int D = 8;
    localparam int L = 3;
    localparam logic [127:0] PT = 128'h71776572747975696f70617364666768;

    typedef struct packed {
        logic [127:0] veri;
        logic         bitti;
    } beklenen_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [95:0] nonce;
    logic [31:0] sayac_ilk;
    logic [15:0] blok_sayisi;
    logic        baslat;
    logic        bitti;
`ifdef AES_CTR_TASMA_KONTROL_EN
    logic        hata;
`endif
    logic        eng_hazir;
    logic        bitti_bos_bek;

    aes_ctr_denetleyici_if bag();

    aes_ctr_denetleyici #(.FIFO_DERINLIK(D), .SAYAC_GENISLIK(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .nonce       (nonce),
        .sayac_ilk   (sayac_ilk),
        .blok_sayisi (blok_sayisi),
        .baslat      (baslat),
        .bag         (bag),
        .bitti       (bitti)
`ifdef AES_CTR_TASMA_KONTROL_EN
        ,
        .hata        (hata)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] ks(input logic [127:0] x);
        return {x[95:0], x[127:96]} ^ {4{x[31:0] ^ 32'h9e3779b9}} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    // Engine model: fixed latency, always pipelined, returns ks(counter block).
    logic [L-1:0] vp;
    logic [127:0] dp [L];
    assign bag.e_hazir     = eng_hazir;
    assign bag.e_c_gecerli = vp[L-1];
    assign bag.e_sifre     = dp[L-1];

    always @(posedge clk) begin
        if (rst) vp <= '0;
        else begin
            vp    <= {vp[L-2:0], bag.e_gecerli & bag.e_hazir};
            dp[0] <= ks(bag.e_blok);
            for (int i = 1; i < L; i++) dp[i] <= dp[i-1];
        end
    end

    beklenen_t    sb_q[$];
    beklenen_t    dexp_q[$];
    logic [127:0] issue_q[$];
    logic [127:0] din_q[$];
    logic [127:0] cap_q[$];
    logic [127:0] sifreli[$];
    int vektor = 0;
    int hatali = 0;

    task automatic kontrol(input string ad, input logic [127:0] gercek, input logic [127:0] beklenen);
        vektor++;
        if (gercek !== beklenen) begin
            hatali++;
            $display("FAIL %s: got %h expected %h", ad, gercek, beklenen);
        end
    endtask

    task automatic hata_yaz(input string ad);
        vektor++;
        hatali++;
        $display("FAIL %s: event occurred but was not expected", ad);
    endtask

    // Monitor: checks issued counter blocks and result blocks against the queues.
    always @(negedge clk) begin
        beklenen_t b;
        #2;
        if (!rst) begin
            if (bag.e_gecerli && bag.e_hazir) begin
                if (issue_q.size() == 0) hata_yaz("unexpected_issue");
                else kontrol("e_blok", bag.e_blok, issue_q.pop_front());
            end
            if (bag.cikti_gecerli) begin
                cap_q.push_back(bag.cikti);
                if (sb_q.size() == 0) hata_yaz("unexpected_cikti");
                else begin
                    b = sb_q.pop_front();
                    kontrol("cikti", bag.cikti, b.veri);
                    kontrol("bitti", 128'(bitti), 128'(b.bitti));
                end
            end else begin
                kontrol("bitti_idle", 128'(bitti), 128'(bitti_bos_bek));
            end
        end
    end

    task automatic is_hazirla(input logic [95:0] nn, input logic [31:0] c, input int n);
        for (int k = 0; k < n; k++) issue_q.push_back({nn, c + 32'(k)});
    endtask

    task automatic ekle(input logic [127:0] d, input logic [127:0] e, input logic son);
        beklenen_t b;
        b.veri  = e;
        b.bitti = son;
        din_q.push_back(d);
        dexp_q.push_back(b);
    endtask

    task automatic baslat_is(input logic [95:0] nn, input logic [31:0] c, input logic [15:0] n);
        @(negedge clk);
        nonce = nn; sayac_ilk = c; blok_sayisi = n; baslat = 1'b1;
        @(negedge clk);
        baslat = 1'b0;
        if (n == 0) begin
            bitti_bos_bek = 1'b1;
            @(negedge clk);
            bitti_bos_bek = 1'b0;
        end
    endtask

    task automatic besle();
        int sinir = 0;
        while (din_q.size() > 0 && sinir < 500) begin
            @(negedge clk);
            bag.d_gecerli = 1'b1;
            bag.d_blok    = din_q[0];
            #1;
            if (bag.d_hazir) begin
                void'(din_q.pop_front());
                sb_q.push_back(dexp_q.pop_front());
            end
            sinir++;
        end
        @(negedge clk);
        bag.d_gecerli = 1'b0;
        if (din_q.size() > 0) hata_yaz("feed_timeout");
        din_q.delete();
        dexp_q.delete();
    endtask

    task automatic bosalt_bekle();
        int s = 0;
        while ((sb_q.size() > 0 || issue_q.size() > 0) && s < 200) begin
            @(negedge clk);
            s++;
        end
        if (s >= 200) hata_yaz("drain_timeout");
        repeat (2) @(negedge clk);
    endtask

    task automatic cikislar_sifir(input string ad);
        kontrol({ad, "_d_hazir"},       128'(bag.d_hazir),       '0);
        kontrol({ad, "_e_gecerli"},     128'(bag.e_gecerli),     '0);
        kontrol({ad, "_e_blok"},        bag.e_blok,              '0);
        kontrol({ad, "_cikti"},         bag.cikti,               '0);
        kontrol({ad, "_cikti_gecerli"}, 128'(bag.cikti_gecerli), '0);
        kontrol({ad, "_bitti"},         128'(bitti),             '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [95:0] nn;
        int ih, cnt, s;
        rst = 1'b1; baslat = 1'b0; nonce = '0; sayac_ilk = '0; blok_sayisi = '0;
        bag.d_gecerli = 1'b0; bag.d_blok = '0; eng_hazir = 1'b1; bitti_bos_bek = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        cikislar_sifir("reset");
`ifdef AES_CTR_TASMA_KONTROL_EN
        kontrol("reset_hata", 128'(hata), '0);
`endif
        rst = 1'b0;

        // Zero plaintext: result is the raw keystream of counters 0,1,2.
        is_hazirla('0, '0, 3);
        for (int k = 0; k < 3; k++) ekle('0, ks({96'h0, 32'(k)}), k == 2);
        baslat_is('0, '0, 3);
        besle();
        bosalt_bekle();

        // Encrypt then replay the ciphertext with the same nonce/counter.
        nn = 96'hdeadbeef_cafef00d_01234567;
        cap_q.delete();
        is_hazirla(nn, 32'h10, 3);
        for (int k = 0; k < 3; k++) ekle(PT, PT ^ ks({nn, 32'h10 + 32'(k)}), k == 2);
        baslat_is(nn, 32'h10, 3);
        besle();
        bosalt_bekle();
        sifreli = cap_q;
        if (sifreli.size() != 3) hata_yaz("capture_count");
        else begin
            is_hazirla(nn, 32'h10, 3);
            for (int k = 0; k < 3; k++) ekle(sifreli[k], PT, k == 2);
            baslat_is(nn, 32'h10, 3);
            besle();
            bosalt_bekle();
        end

        // Sink stalled 20 cycles: issue must stop at the FIFO depth.
        nn = 96'h1;
        is_hazirla(nn, 32'h100, 12);
        for (int k = 0; k < 12; k++)
            ekle({4{32'(k) ^ 32'h5a5a0000}}, {4{32'(k) ^ 32'h5a5a0000}} ^ ks({nn, 32'h100 + 32'(k)}), k == 11);
        baslat_is(nn, 32'h100, 12);
        ih = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bag.e_gecerli && bag.e_hazir) ih++;
            @(negedge clk);
        end
        #1;
        kontrol("credit_stall_count", 128'(ih), 128'(D));
        kontrol("credit_stall_e_gecerli", 128'(bag.e_gecerli), '0);
        besle();
        bosalt_bekle();

        // Counter wrap.
        nn = 96'ha5;
        issue_q.push_back({nn, 32'hffffffff - 32'h1});
        issue_q.push_back({nn, 32'hffffffff});
`ifndef AES_CTR_TASMA_KONTROL_EN
        issue_q.push_back({nn, 32'h00000000});
        for (int k = 0; k < 3; k++) ekle('0, ks({nn, 32'hfffffffe + 32'(k)}), k == 2);
        baslat_is(nn, 32'hfffffffe, 3);
        besle();
        bosalt_bekle();
`else
        for (int k = 0; k < 2; k++) ekle('0, ks({nn, 32'hfffffffe + 32'(k)}), 1'b0);
        baslat_is(nn, 32'hfffffffe, 3);
        besle();
        bosalt_bekle();
        kontrol("wrap_hata", 128'(hata), 128'(1));
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        #1;
        kontrol("wrap_hata_cleared", 128'(hata), '0);
`endif

        // Reset after 2 of 5 blocks issued, then a clean 5-block job.
        nn = 96'h77;
        is_hazirla(nn, 32'h20, 5);
        baslat_is(nn, 32'h20, 5);
        cnt = 0; s = 0;
        while (cnt < 2 && s < 50) begin
            #1;
            if (bag.e_gecerli && bag.e_hazir) cnt++;
            @(negedge clk);
            s++;
        end
        eng_hazir = 1'b0;
        if (cnt < 2) hata_yaz("midjob_issue_timeout");
        @(negedge clk);
        rst = 1'b1;
        issue_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        cikislar_sifir("midjob_reset");
        eng_hazir = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        kontrol("midjob_idle_e_gecerli", 128'(bag.e_gecerli), '0);
        is_hazirla(nn, 32'h20, 5);
        for (int k = 0; k < 5; k++) ekle(PT ^ 128'(k), PT ^ 128'(k) ^ ks({nn, 32'h20 + 32'(k)}), k == 4);
        baslat_is(nn, 32'h20, 5);
        besle();
        bosalt_bekle();

        // Empty job: bitti next cycle, nothing issued, no output.
        baslat_is(96'h3, 32'h0, 16'd0);
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vektor, hatali);
        $finish;
    end

endmodule

// File: doc/aes_ctr_denetleyici.md
# aes_ctr_denetleyici

Counter-mode (CTR) front/back end for `aes_engine`. It generates the counter blocks fed to the engine's `blok`/`g_gecerli`/`hazir` input side. It collects the engine's `sifre`/`c_gecerli` output as keystream in a credit-limited FIFO. It XORs that keystream with an incoming plaintext stream to produce the encrypted or decrypted stream. It sits between a data source/sink and one `aes_engine` instance sharing its clock and reset.

## Interface
Parameters:
- `FIFO_DERINLIK`, 8: keystream FIFO depth in blocks, power of two, 2..32.
- `SAYAC_GENISLIK`, 32: counter field width; upper `128-SAYAC_GENISLIK` bits are nonce.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset; shared with `aes_engine`.
- `nonce`  in  128-SAYAC_GENISLIK  nonce, sampled at `baslat`.
- `sayac_ilk`  in  SAYAC_GENISLIK  initial counter, sampled at `baslat`.
- `blok_sayisi`  in  16  number of blocks in job, sampled at `baslat`.
- `baslat`  in  1  start pulse, honoured only in BOS.
- `d_blok`  in  128  plaintext/ciphertext input block.
- `d_gecerli`  in  1  `d_blok` valid.
- `d_hazir`  out  1  input block accepted this cycle when high with `d_gecerli`.
- `e_blok`  out  128  counter block to engine `blok`.
- `e_gecerli`  out  1  to engine `g_gecerli`.
- `e_hazir`  in  1  from engine `hazir`.
- `e_sifre`  in  128  from engine `sifre`.
- `e_c_gecerli`  in  1  from engine `c_gecerli`.
- `cikti`  out  128  result block, `d_blok ^ keystream`.
- `cikti_gecerli`  out  1  one-cycle qualifier for `cikti`.
- `bitti`  out  1  one-cycle pulse when the job's last block leaves.
- `hata`  out  1  sticky error flag; exists only with `AES_CTR_TASMA_KONTROL_EN`.

## Operation
- States: BOS → CALISIYOR → BOSALT → BOS.
  - BOS: `baslat` latches `nonce`, `sayac_ilk` and `blok_sayisi`.
    - If `blok_sayisi`==0, stay in BOS and pulse `bitti` the next cycle.
    - Otherwise go to CALISIYOR.
- Issue rule, CALISIYOR only: `e_gecerli`=1 when `kalan_ihrac`>0 and `ucusta + doluluk < FIFO_DERINLIK`.
  - `ucusta` counts blocks issued to the engine and not yet returned.
  - `doluluk` is FIFO occupancy.
  - A transfer happens when `e_gecerli & e_hazir`. On a transfer: counter +1 modulo 2^SAYAC_GENISLIK, `kalan_ihrac` −1, `ucusta` +1.
- `e_blok` = {nonce_reg, sayac_reg}, held stable while `e_gecerli & ~e_hazir`.
- Issuing the last block moves CALISIYOR → BOSALT.
- Every `e_c_gecerli` pushes `e_sifre` into the FIFO and decrements `ucusta`. The credit rule guarantees the FIFO never overflows.
- Output consumption: `d_hazir` = FIFO non-empty and `kalan_cikti`>0 and state≠BOS.
  - On `d_gecerli & d_hazir`: pop FIFO, register `cikti`, decrement `kalan_cikti`.
- When `kalan_cikti` goes 1→0: `bitti` pulses with the final `cikti_gecerli`, and the state returns to BOS.
- Simultaneous push/pop, or issue and return in the same cycle: both counters update net, with occupancy or `ucusta` unchanged.
- `baslat` outside BOS is ignored.

## Timing
- Reset values: `d_hazir`=0, `e_gecerli`=0, `e_blok`=0, `cikti`=0, `cikti_gecerli`=0, `bitti`=0, `hata`=0. State BOS; all counters and the FIFO cleared.
- `e_gecerli` is asserted no earlier than the cycle after `baslat`.
- `cikti`/`cikti_gecerli` appear one cycle after the accepting `d_gecerli & d_hazir` edge.
- Throughput is one block per cycle when the engine is pipelined and `FIFO_DERINLIK` ≥ engine latency + 1.
- Reset mid-job: immediate return to BOS on the next edge. The engine is reset in the same cycle, so no stale `e_c_gecerli` is accepted.
- Counter wrap: 0xFFFFFFFF is followed by 0x00000000 unless the macro below is enabled.

## Configuration
- `AES_CTR_TASMA_KONTROL_EN` defined:
  - An issue that would wrap the counter instead sets `hata` (sticky until `rst`) and stops further issue.
  - Blocks already issued still drain; `bitti` is never asserted for that job.
- Macro undefined: the counter wraps silently, and `hata` is absent from the port list.

## Structure
- Shared package `aes_pkg`:
  - `AES_BLOK_GENISLIK`=128.
  - State encodings `DURUM_BOS`/`DURUM_CALISIYOR`/`DURUM_BOSALT`.
  - Counter/credit width helper constants.
- Sub-module `aes_ctr_fifo`: synchronous FIFO of 128-bit entries, depth `FIFO_DERINLIK`, outputs `dolu`, `bos` and `doluluk`. The controller holds the FSM, the counters and the XOR register.

## Test plan
- nonce=0, sayac_ilk=0, blok_sayisi=3, engine always ready → `e_blok` = 0, 1, 2 on consecutive cycles. With `d_blok`=0, `cikti` equals the engine's `sifre` for blocks 0..2, and `bitti` pulses with the third `cikti_gecerli`.
- Same job, then replay `cikti` as `d_blok` in a second job with an identical nonce and counter → `cikti` returns the original plaintext 0x71776572747975696f70617364666768.
- `d_gecerli` held low for 20 cycles, FIFO_DERINLIK=8 → `e_gecerli` stalls once `ucusta + doluluk` = 8. No block is lost, and output order matches counter order.
- sayac_ilk=0xFFFFFFFE, blok_sayisi=3 → without the macro, counters FFFFFFFE, FFFFFFFF, 00000000. With the macro, `hata`=1 after 2 issues and no `bitti`.
- `rst` pulsed for one cycle mid-job after 2 of 5 blocks → all outputs read 0 and state is BOS. A fresh `baslat` then runs a clean 5-block job.
- blok_sayisi=0 with `baslat` → `bitti` pulses the next cycle with no `e_gecerli` and no `cikti_gecerli`.
